// File: rtl/strip_trigger_serializer.sv
// strip_trigger_serializer
//
// Queues parallel trigger frames in a small FIFO. Each frame is shifted out
// MSB first on N_LANES serial lanes, one bit per clk cycle, with a forwarded
// clock at clk/2. After every frame the block forces GAP idle cycles.
//
// Ports
//   clk          bit clock; every trig_d bit lasts one cycle
//   reset_n      asynchronous active-low reset
//   enable       permits the start of new frames
//   trig_load    single-cycle strobe that captures frame_data into the FIFO
//   frame_data   lane i = frame_data[(i+1)*FRAME_LEN-1 : i*FRAME_LEN]
//   clear_stats  synchronous clear of drop_count and frame_count
//   trig_clk     forwarded clock (toggle register XOR TRIG_CLK_INV)
//   trig_en      high while frame bits are on trig_d
//   trig_d       serial data, one bit per lane
//   busy         FSM not idle, or frames still pending
//   fifo_level   FIFO occupancy, 0..DEPTH
//   drop_count   saturating count of loads lost to a full FIFO
//   frame_count  wrapping count of completed frames

module strip_trigger_serializer #(
    parameter int N_LANES      = 2,
    parameter int FRAME_LEN    = 13,
    parameter int DEPTH        = 4,
    parameter int GAP          = 3,
    parameter bit TRIG_CLK_INV = 1'b0
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           enable,
    input  logic                           trig_load,
    input  logic [N_LANES*FRAME_LEN-1:0]   frame_data,
    input  logic                           clear_stats,
    output logic                           trig_clk,
    output logic                           trig_en,
    output logic [N_LANES-1:0]             trig_d,
    output logic                           busy,
    output logic [$clog2(DEPTH):0]         fifo_level,
    output logic [7:0]                     drop_count,
    output logic [15:0]                    frame_count
);

    localparam int W  = N_LANES * FRAME_LEN;
    localparam int AW = $clog2(DEPTH);
    localparam int BW = $clog2(FRAME_LEN);

    localparam logic [BW-1:0] LAST_BIT   = BW'(FRAME_LEN - 1);
    localparam logic [3:0]    LAST_GAP   = 4'(GAP - 1);
    localparam logic [AW:0]   FULL_LEVEL = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t           state_q;
    logic [W-1:0]     mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      level_q;
    logic [AW:0]      level_d;
    logic [W-1:0]     shift_q;
    logic [BW-1:0]    bit_cnt_q;
    logic [3:0]       gap_cnt_q;
    logic             trig_en_q;
    logic [N_LANES-1:0] trig_d_q;
    logic             toggle_q;
    logic [7:0]       drop_count_q;
    logic [15:0]      frame_count_q;

    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             drop;
    logic             pop;
    logic             frame_done;
    logic [W-1:0]     head;
    logic [W-1:0]     head_shl;
    logic [W-1:0]     shift_shl;
    logic [N_LANES-1:0] head_msb;
    logic [N_LANES-1:0] shift_msb;

    // Fullness is judged on the registered level, so a load that meets a
    // full FIFO is dropped even if the FSM pops in the same cycle.
    assign fifo_full  = (level_q == FULL_LEVEL);
    assign fifo_empty = (level_q == '0);
    assign push       = trig_load & ~fifo_full;
    assign drop       = trig_load & fifo_full;
    assign pop        = (state_q == S_IDLE) & enable & ~fifo_empty;
    assign frame_done = (state_q == S_SHIFT) && (bit_cnt_q == LAST_BIT);
    assign head       = mem_q[rd_ptr_q];

    // Per-lane MSB taps and per-lane left shifts, both for the FIFO head
    // (used on the pop cycle) and for the running shift register.
    always_comb begin
        head_msb  = '0;
        shift_msb = '0;
        head_shl  = '0;
        shift_shl = '0;
        for (int i = 0; i < N_LANES; i++) begin
            head_msb[i]  = head[i*FRAME_LEN + FRAME_LEN - 1];
            shift_msb[i] = shift_q[i*FRAME_LEN + FRAME_LEN - 1];
            head_shl[i*FRAME_LEN +: FRAME_LEN]  = {head[i*FRAME_LEN +: FRAME_LEN-1], 1'b0};
            shift_shl[i*FRAME_LEN +: FRAME_LEN] = {shift_q[i*FRAME_LEN +: FRAME_LEN-1], 1'b0};
        end
    end

    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + (AW + 1)'(1);
            2'b01:   level_d = level_q - (AW + 1)'(1);
            default: level_d = level_q;
        endcase
    end

    // Storage has no reset; only the pointers and level define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= frame_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            level_q <= level_d;
        end
    end

    // Frame FSM with registered serial outputs. The pop cycle already puts
    // the MSBs on trig_d, so the first bit is visible one cycle after the
    // pop; bit_cnt_q is the index of the bit currently on the lanes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            gap_cnt_q     <= '0;
            trig_en_q     <= 1'b0;
            trig_d_q      <= '0;
            toggle_q      <= 1'b0;
            drop_count_q  <= '0;
            frame_count_q <= '0;
        end else begin
            toggle_q <= ~toggle_q;

            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        shift_q   <= head_shl;
                        trig_d_q  <= head_msb;
                        trig_en_q <= 1'b1;
                        bit_cnt_q <= '0;
                        state_q   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (bit_cnt_q == LAST_BIT) begin
                        trig_en_q <= 1'b0;
                        trig_d_q  <= '0;
                        gap_cnt_q <= '0;
                        state_q   <= S_GAP;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + BW'(1);
                        shift_q   <= shift_shl;
                        trig_d_q  <= shift_msb;
                    end
                end
                S_GAP: begin
                    if (gap_cnt_q == LAST_GAP) begin
                        state_q <= S_IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 4'd1;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    trig_en_q <= 1'b0;
                    trig_d_q  <= '0;
                end
            endcase

            // clear_stats wins over any same-cycle increment.
            if (clear_stats) begin
                drop_count_q  <= '0;
                frame_count_q <= '0;
            end else begin
                if (drop && (drop_count_q != 8'hFF)) begin
                    drop_count_q <= drop_count_q + 8'd1;
                end
                if (frame_done) begin
                    frame_count_q <= frame_count_q + 16'd1;
                end
            end
        end
    end

    assign trig_clk    = toggle_q ^ TRIG_CLK_INV;
    assign trig_en     = trig_en_q;
    assign trig_d      = trig_d_q;
    assign busy        = (state_q != S_IDLE) | ~fifo_empty;
    assign fifo_level  = level_q;
    assign drop_count  = drop_count_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_strip_trigger_serializer.sv
// tb_strip_trigger_serializer
//
// Directed bench for strip_trigger_serializer. One instance uses the default
// parameters; a second instance uses N_LANES=4, FRAME_LEN=8, GAP=1,
// TRIG_CLK_INV=1. Negedge monitors record every frame start cycle and every
// serial word so frames can be checked after multi-frame sequences.

module tb_strip_trigger_serializer;

    localparam int FL  = 13;
    localparam int FL2 = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        trig_load;
    logic [25:0] frame_data;
    logic        clear_stats;
    logic        trig_clk;
    logic        trig_en;
    logic [1:0]  trig_d;
    logic        busy;
    logic [2:0]  fifo_level;
    logic [7:0]  drop_count;
    logic [15:0] frame_count;

    logic        enable2;
    logic        trig_load2;
    logic [31:0] frame_data2;
    logic        clear_stats2;
    logic        trig_clk2;
    logic        trig_en2;
    logic [3:0]  trig_d2;
    logic        busy2;
    logic [2:0]  fifo_level2;
    logic [7:0]  drop_count2;
    logic [15:0] frame_count2;

    int cycle;
    int assertCount;
    int failCount;

    int         startQ[$];
    logic [1:0] bitsQ[$];
    logic       prevEn;
    int         startQ2[$];
    logic [3:0] bitsQ2[$];
    logic       prevEn2;

    logic [25:0] burst [6];

    strip_trigger_serializer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .trig_load   (trig_load),
        .frame_data  (frame_data),
        .clear_stats (clear_stats),
        .trig_clk    (trig_clk),
        .trig_en     (trig_en),
        .trig_d      (trig_d),
        .busy        (busy),
        .fifo_level  (fifo_level),
        .drop_count  (drop_count),
        .frame_count (frame_count)
    );

    strip_trigger_serializer #(
        .N_LANES      (4),
        .FRAME_LEN    (8),
        .DEPTH        (4),
        .GAP          (1),
        .TRIG_CLK_INV (1'b1)
    ) dut2 (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable2),
        .trig_load   (trig_load2),
        .frame_data  (frame_data2),
        .clear_stats (clear_stats2),
        .trig_clk    (trig_clk2),
        .trig_en     (trig_en2),
        .trig_d      (trig_d2),
        .busy        (busy2),
        .fifo_level  (fifo_level2),
        .drop_count  (drop_count2),
        .frame_count (frame_count2)
    );

    always #5 clk = ~clk;

    // Record frame start cycles and serial words, sampled mid-cycle.
    always @(negedge clk) begin
        if (trig_en) begin
            if (!prevEn) startQ.push_back(cycle);
            bitsQ.push_back(trig_d);
        end
        prevEn = trig_en;
        if (trig_en2) begin
            if (!prevEn2) startQ2.push_back(cycle);
            bitsQ2.push_back(trig_d2);
        end
        prevEn2 = trig_en2;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic tickN(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic applyStimulus(input logic [25:0] data);
        trig_load  = 1'b1;
        frame_data = data;
        tick();
        trig_load  = 1'b0;
    endtask

    task automatic clearQueues();
        startQ.delete();
        bitsQ.delete();
        startQ2.delete();
        bitsQ2.delete();
    endtask

    // Compare recorded frame idx against the expected lane words of data.
    task automatic checkFrame(input string tag, input int idx, input logic [25:0] data);
        logic [1:0] exp;
        if (bitsQ.size() < (idx + 1) * FL) begin
            checkOutput({tag, " missing"}, 32'(bitsQ.size()), 32'((idx + 1) * FL));
            return;
        end
        for (int b = 0; b < FL; b++) begin
            exp = {data[FL + FL - 1 - b], data[FL - 1 - b]};
            checkOutput(tag, 32'(bitsQ[idx*FL + b]), 32'(exp));
        end
    endtask

    task automatic checkFrame2(input string tag, input int idx, input logic [31:0] data);
        logic [3:0] exp;
        if (bitsQ2.size() < (idx + 1) * FL2) begin
            checkOutput({tag, " missing"}, 32'(bitsQ2.size()), 32'((idx + 1) * FL2));
            return;
        end
        for (int b = 0; b < FL2; b++) begin
            for (int i = 0; i < 4; i++) exp[i] = data[i*FL2 + FL2 - 1 - b];
            checkOutput(tag, 32'(bitsQ2[idx*FL2 + b]), 32'(exp));
        end
    endtask

    initial begin
        int t;
        int c0;
        int x;
        int y;
        int t2;
        logic [31:0] fA;
        logic [31:0] fB;

        burst[0] = 26'h0000001;
        burst[1] = 26'h3FFFFFF;
        burst[2] = 26'h2AAAAAA;
        burst[3] = 26'h1555555;
        burst[4] = 26'h0F0F0F0;
        burst[5] = 26'h3123456;
        fA = 32'hA53CF081;
        fB = 32'h0F1E2D3C;

        cycle = 0; assertCount = 0; failCount = 0;
        prevEn = 1'b0; prevEn2 = 1'b0;
        reset_n = 1'b1; enable = 1'b0; trig_load = 1'b0; frame_data = '0;
        clear_stats = 1'b0; enable2 = 1'b0; trig_load2 = 1'b0;
        frame_data2 = '0; clear_stats2 = 1'b0;
        #2 reset_n = 1'b0;
        tickN(3);

        // Reset state
        checkOutput("reset trig_en", 32'(trig_en), 0);
        checkOutput("reset trig_d", 32'(trig_d), 0);
        checkOutput("reset busy", 32'(busy), 0);
        checkOutput("reset fifo_level", 32'(fifo_level), 0);
        checkOutput("reset drop_count", 32'(drop_count), 0);
        checkOutput("reset frame_count", 32'(frame_count), 0);
        checkOutput("reset trig_clk", 32'(trig_clk), 0);
        checkOutput("reset trig_clk inv", 32'(trig_clk2), 1);

        // Single frame, loaded in the first cycle after reset release
        enable  = 1'b1;
        t       = cycle;
        reset_n = 1'b1;
        clearQueues();
        applyStimulus({13'h1555, 13'h0ABC});
        checkOutput("single level", 32'(fifo_level), 1);
        checkOutput("single busy", 32'(busy), 1);
        checkOutput("single pre trig_en", 32'(trig_en), 0);
        checkOutput("trig_clk phase t+1", 32'(trig_clk), 1);
        tickN(13);
        checkOutput("single last bit", 32'({trig_en, trig_d}), 32'b110);
        checkOutput("single count before", 32'(frame_count), 0);
        tick();
        checkOutput("single gap outputs", 32'({trig_en, trig_d}), 0);
        checkOutput("single frame_count", 32'(frame_count), 1);
        checkOutput("single gap busy", 32'(busy), 1);
        tickN(3);
        checkOutput("single idle busy", 32'(busy), 0);
        checkOutput("trig_clk phase", 32'(trig_clk), 32'((cycle - t) & 1));
        checkOutput("trig_clk inv phase", 32'(trig_clk2), 32'(((cycle - t) & 1) ^ 1));
        checkOutput("single starts", 32'(startQ.size()), 1);
        if (startQ.size() >= 1) checkOutput("single latency", 32'(startQ[0]), 32'(t + 2));
        checkOutput("single width", 32'(bitsQ.size()), FL);
        checkFrame("single data", 0, {13'h1555, 13'h0ABC});

        // Burst of six loads into a depth-4 FIFO
        clearQueues();
        c0 = cycle;
        for (int k = 0; k < 6; k++) applyStimulus(burst[k]);
        checkOutput("burst level", 32'(fifo_level), 4);
        checkOutput("burst drop", 32'(drop_count), 1);
        tickN(100);
        checkOutput("burst starts", 32'(startQ.size()), 5);
        if (startQ.size() == 5) begin
            checkOutput("burst first", 32'(startQ[0]), 32'(c0 + 2));
            for (int k = 1; k < 5; k++)
                checkOutput("burst spacing", 32'(startQ[k] - startQ[k-1]), 17);
        end
        for (int k = 0; k < 5; k++) checkFrame("burst data", k, burst[k]);
        checkOutput("burst frame_count", 32'(frame_count), 6);
        checkOutput("burst drained", 32'(fifo_level), 0);
        checkOutput("burst busy", 32'(busy), 0);

        // Load while full in the same cycle as a pop
        enable = 1'b0;
        clearQueues();
        for (int k = 0; k < 4; k++) applyStimulus(burst[k]);
        checkOutput("full level", 32'(fifo_level), 4);
        enable = 1'b1;
        applyStimulus(26'h0123456);
        checkOutput("full pop level", 32'(fifo_level), 3);
        checkOutput("full pop drop", 32'(drop_count), 2);
        tickN(90);
        checkOutput("full pop starts", 32'(startQ.size()), 4);
        for (int k = 0; k < 4; k++) checkFrame("full pop data", k, burst[k]);
        checkOutput("full pop frame_count", 32'(frame_count), 10);
        checkOutput("full pop drained", 32'(fifo_level), 0);

        // enable dropped at bit 5 with frames queued
        enable = 1'b0;
        clearQueues();
        for (int k = 3; k < 6; k++) applyStimulus(burst[k]);
        x = cycle;
        enable = 1'b1;
        tick();
        tickN(5);
        checkOutput("pause bit5 trig_en", 32'(trig_en), 1);
        enable = 1'b0;
        tickN(19);
        checkOutput("pause width", 32'(bitsQ.size()), FL);
        checkOutput("pause starts", 32'(startQ.size()), 1);
        checkOutput("pause level", 32'(fifo_level), 2);
        checkOutput("pause busy", 32'(busy), 1);
        checkOutput("pause trig_en", 32'(trig_en), 0);
        checkOutput("pause frame_count", 32'(frame_count), 11);
        checkFrame("pause data", 0, burst[3]);
        y = cycle;
        enable = 1'b1;
        tickN(2);
        if (startQ.size() >= 2)
            checkOutput("reenable latency", 32'((startQ[1] - y >= 1) && (startQ[1] - y <= 2)), 1);
        else
            checkOutput("reenable start", 32'(startQ.size()), 2);
        tickN(40);
        checkOutput("reenable frame_count", 32'(frame_count), 13);
        checkOutput("reenable drained", 32'(fifo_level), 0);
        checkFrame("reenable data", 1, burst[4]);
        checkFrame("reenable data", 2, burst[5]);

        // clear_stats beats a same-cycle drop
        enable = 1'b0;
        clearQueues();
        for (int k = 0; k < 4; k++) applyStimulus(burst[k]);
        clear_stats = 1'b1;
        applyStimulus(burst[4]);
        clear_stats = 1'b0;
        checkOutput("clear drop", 32'(drop_count), 0);
        checkOutput("clear frame", 32'(frame_count), 0);
        applyStimulus(burst[5]);
        checkOutput("drop after clear", 32'(drop_count), 1);

        // Reset pulsed at bit 7 of a frame
        enable = 1'b1;
        tick();
        tickN(7);
        checkOutput("abort in frame", 32'(trig_en), 1);
        reset_n = 1'b0;
        #2;
        checkOutput("abort trig_en", 32'(trig_en), 0);
        checkOutput("abort trig_d", 32'(trig_d), 0);
        checkOutput("abort level", 32'(fifo_level), 0);
        checkOutput("abort busy", 32'(busy), 0);
        checkOutput("abort frame_count", 32'(frame_count), 0);
        checkOutput("abort drop_count", 32'(drop_count), 0);
        checkOutput("abort trig_clk", 32'(trig_clk), 0);
        checkOutput("abort trig_clk inv", 32'(trig_clk2), 1);
        tick();

        // Parameter sweep instance, loaded right after release
        clearQueues();
        t2 = cycle;
        reset_n     = 1'b1;
        enable2     = 1'b1;
        trig_load2  = 1'b1;
        frame_data2 = fA;
        tick();
        frame_data2 = fB;
        tick();
        trig_load2  = 1'b0;
        tickN(30);
        checkOutput("sweep starts", 32'(startQ2.size()), 2);
        if (startQ2.size() == 2) begin
            checkOutput("sweep latency", 32'(startQ2[0]), 32'(t2 + 2));
            checkOutput("sweep spacing", 32'(startQ2[1] - startQ2[0]), 10);
        end
        checkOutput("sweep width", 32'(bitsQ2.size()), 2 * FL2);
        checkFrame2("sweep data", 0, fA);
        checkFrame2("sweep data", 1, fB);
        checkOutput("sweep frame_count", 32'(frame_count2), 2);
        checkOutput("sweep trig_clk inv", 32'(trig_clk2), 32'(((cycle - t2) & 1) ^ 1));
        checkOutput("post abort frame_count", 32'(frame_count), 0);
        checkOutput("post abort trig_en", 32'(trig_en), 0);
        checkOutput("post abort starts", 32'(startQ.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
